// File: rtl/axi_wr_pkg.sv
// Shared types and constants for the AXI write responder, plus the AXI bus width macros.
// The optional macro AXI_WR_RANGE_CHECK_EN (see axi_wr_slave) is not referenced here.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

package axi_wr_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
endpackage

// File: rtl/axi_wr_beat_gen.sv
// Beat bookkeeping for one write burst: beat counter, last-beat compare and the
// running byte address (WRAP and reserved burst codes advance like INCR).
module axi_wr_beat_gen
    import axi_wr_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              is_last
);
    logic [LEN_W-1:0]  cnt;
    logic [LEN_W-1:0]  len_q;
    logic [1:0]        burst_q;
    logic [ADDR_W-1:0] addr_nxt;

    always_comb begin
        addr_nxt = cur_addr + ADDR_W'(4);
        case (burst_q)
            BURST_FIXED: addr_nxt = cur_addr;
            BURST_INCR,
            BURST_WRAP:  addr_nxt = cur_addr + ADDR_W'(4);
            default:     addr_nxt = cur_addr + ADDR_W'(4);
        endcase
    end

    assign is_last = (cnt == len_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            len_q    <= '0;
            burst_q  <= BURST_FIXED;
            cur_addr <= '0;
        end else if (load) begin
            cnt      <= '0;
            len_q    <= len;
            burst_q  <= burst;
            cur_addr <= start_addr;
        end else if (step) begin
            cnt      <= cnt + LEN_W'(1);
            cur_addr <= addr_nxt;
        end
    end
endmodule

// File: rtl/axi_wr_slave.sv
// AXI slave write responder: one AW burst at a time, W beats to an SRAM write port, then B.
// Optional: define AXI_WR_RANGE_CHECK_EN to reject beats whose word index is >= MEM_WORDS.
module axi_wr_slave
    import axi_wr_pkg::*;
#(
    parameter int MEM_ADDR_W = 14,
    parameter int MEM_WORDS  = 16384
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    input  logic [`AXI_IDS_BITS-1:0]   AWID,
    input  logic [`AXI_ADDR_BITS-1:0]  AWADDR,
    input  logic [`AXI_LEN_BITS-1:0]   AWLEN,
    input  logic [`AXI_SIZE_BITS-1:0]  AWSIZE,
    input  logic [1:0]                 AWBURST,
    input  logic                       AWVALID,
    output logic                       AWREADY,
    input  logic [`AXI_DATA_BITS-1:0]  WDATA,
    input  logic [`AXI_STRB_BITS-1:0]  WSTRB,
    input  logic                       WLAST,
    input  logic                       WVALID,
    output logic                       WREADY,
    output logic [`AXI_IDS_BITS-1:0]   BID,
    output logic [1:0]                 BRESP,
    output logic                       BVALID,
    input  logic                       BREADY,
    output logic                       mem_we,
    output logic [MEM_ADDR_W-1:0]      mem_addr,
    output logic [`AXI_DATA_BITS-1:0]  mem_wdata,
    output logic [`AXI_STRB_BITS-1:0]  mem_wstrb,
    output state_t                     dbg_state
);
`ifdef AXI_WR_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    // Handshake rule on every channel: a transfer happens on a rising edge where
    // VALID and READY are both high; READY/VALID driven here never wait on the peer.
    state_t                    state, state_nxt;
    logic [`AXI_IDS_BITS-1:0]  bid_q;
    logic                      err_q;
    logic                      aw_hs, w_hs, is_last, in_range, beat_err;
    logic [`AXI_ADDR_BITS-1:0] cur_addr;
    logic [MEM_ADDR_W-1:0]     word_idx;
    logic                      unused_bits;

    axi_wr_beat_gen #(
        .ADDR_W (`AXI_ADDR_BITS),
        .LEN_W  (`AXI_LEN_BITS)
    ) u_beat_gen (
        .clk        (ACLK),
        .rst_n      (ARESETn),
        .load       (aw_hs),
        .step       (w_hs),
        .start_addr (AWADDR),
        .len        (AWLEN),
        .burst      (AWBURST),
        .cur_addr   (cur_addr),
        .is_last    (is_last)
    );

    // Ready/valid are gated by reset so nothing handshakes while ARESETn is low.
    assign AWREADY = ARESETn && (state == IDLE);
    assign WREADY  = ARESETn && (state == DATA);
    assign BVALID  = ARESETn && (state == RESP);
    assign aw_hs   = AWVALID && AWREADY;
    assign w_hs    = WVALID && WREADY;

    assign word_idx  = cur_addr[MEM_ADDR_W+1:2];
    assign in_range  = !RANGE_CHECK || (32'(word_idx) < 32'(MEM_WORDS));
    assign beat_err  = (WLAST != is_last) || !in_range;
    assign mem_we    = w_hs && (|WSTRB) && in_range;
    assign mem_addr  = word_idx;
    assign mem_wdata = WDATA;
    assign mem_wstrb = WSTRB;

    assign BID       = bid_q;
    assign BRESP     = err_q ? BRESP_SLVERR : BRESP_OKAY;
    assign dbg_state = state;

    // AWSIZE is ignored (always 4 B) and only the word-index bits of the address reach memory.
    assign unused_bits = ^{AWSIZE, cur_addr[`AXI_ADDR_BITS-1:MEM_ADDR_W+2], cur_addr[1:0]};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (aw_hs) state_nxt = DATA;
            DATA:    if (w_hs && is_last) state_nxt = RESP;
            RESP:    if (BREADY) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state <= IDLE;
            bid_q <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (aw_hs) begin
                bid_q <= AWID;
                err_q <= 1'b0;
            end else if (w_hs && beat_err) begin
                err_q <= 1'b1;
            end
        end
    end
endmodule
